// File: rtl/imc_decoder_pkg.sv
// Shared definitions for the IMC input path: FIFO word width and the
// unpacker state encoding.
package imc_decoder_pkg;

    localparam int unsigned IMC_DATA_WIDTH = 32;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

endpackage

// File: rtl/input_buffer_unpacker.sv
// Pops words from the input FIFO and streams them out as ELEM_WIDTH slices,
// LSB first, for a job of vec_len elements; pulses done at job end.
module input_buffer_unpacker
    import imc_decoder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = IMC_DATA_WIDTH,
    parameter int unsigned ELEM_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  vec_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_cs,
    output logic                  fifo_rd_en,
    output logic                  elem_valid,
    input  logic                  elem_ready,
    output logic [ELEM_WIDTH-1:0] elem_data,
    output logic                  elem_last
);

    localparam int unsigned ELEMS_PER_WORD = DATA_WIDTH / ELEM_WIDTH;
    localparam int unsigned SLICE_WIDTH    = (ELEMS_PER_WORD > 1) ? $clog2(ELEMS_PER_WORD) : 1;
    localparam logic [SLICE_WIDTH-1:0] LAST_SLICE = SLICE_WIDTH'(ELEMS_PER_WORD - 1);

    logic [1:0]             state, state_n;
    logic [LEN_WIDTH-1:0]   rem_cnt, rem_cnt_n;
    logic [SLICE_WIDTH-1:0] slice_idx, slice_idx_n;
    logic                   rd_en;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rem_cnt   <= '0;
            slice_idx <= '0;
        end else begin
            state     <= state_n;
            rem_cnt   <= rem_cnt_n;
            slice_idx <= slice_idx_n;
        end
    end

    // Next-state, counters and pop request
    always_comb begin
        state_n     = state;
        rem_cnt_n   = rem_cnt;
        slice_idx_n = slice_idx;
        rd_en       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    rem_cnt_n = vec_len;
                    state_n   = (vec_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (!fifo_empty) begin
                    rd_en       = 1'b1;
                    slice_idx_n = '0;
                    state_n     = STREAM;
                end
            end
            STREAM: begin
                if (elem_ready) begin
                    if (rem_cnt == LEN_WIDTH'(1)) begin
                        // Remaining slices of the current word are dropped.
                        state_n = DONE;
                    end else begin
                        rem_cnt_n = rem_cnt - LEN_WIDTH'(1);
                        if (slice_idx == LAST_SLICE) begin
                            slice_idx_n = '0;
                            // Pop in the same cycle to keep the stream bubble-free.
                            if (!fifo_empty) begin
                                rd_en = 1'b1;
                            end else begin
                                state_n = FETCH;
                            end
                        end else begin
                            slice_idx_n = slice_idx + SLICE_WIDTH'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; the FIFO's held data_out is the word buffer
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign elem_valid = (state == STREAM);
    assign elem_last  = elem_valid && (rem_cnt == LEN_WIDTH'(1));
    assign fifo_rd_en = rd_en;
    assign fifo_rd_cs = rd_en;
    assign elem_data  = ELEM_WIDTH'(fifo_data >> (32'(slice_idx) * ELEM_WIDTH));

endmodule

// File: tb/tb_input_buffer_unpacker.sv
// Self-checking bench for input_buffer_unpacker with a behavioural FIFO and
// an element-index model of the expected output stream.
`timescale 1ns/1ps
module tb_input_buffer_unpacker;

    localparam int unsigned DW  = 32;
    localparam int unsigned EW  = 8;
    localparam int unsigned LW  = 16;
    localparam int unsigned EPW = DW / EW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] vec_len;
    logic          busy;
    logic          done;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_cs;
    logic          fifo_rd_en;
    logic          elem_valid;
    logic          elem_ready;
    logic [EW-1:0] elem_data;
    logic          elem_last;

    always #5 clk = ~clk;

    input_buffer_unpacker #(
        .DATA_WIDTH (DW),
        .ELEM_WIDTH (EW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .vec_len    (vec_len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_cs (fifo_rd_cs),
        .fifo_rd_en (fifo_rd_en),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .elem_data  (elem_data),
        .elem_last  (elem_last)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural FIFO: registered data_out, one-cycle read latency
    logic          push_valid;
    logic [DW-1:0] push_word;
    logic [DW-1:0] fifo_q[$];

    always @(posedge clk) begin
        if (!rst) begin
            fifo_q.delete();
            fifo_data  <= '0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
            if (push_valid) fifo_q.push_back(push_word);
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // Model state, written only by the compare process
    logic [DW-1:0] model_words[$];
    logic [EW-1:0] acc_log[$];
    int            acc_cyc[$];
    int            pop_cyc[$];
    bit            job_active = 1'b0;
    bit            exp_done   = 1'b0;
    bit            chk_reset  = 1'b0;
    bit            stall_prev = 1'b0;
    logic [EW-1:0] prev_data;
    logic          prev_last;
    int            job_len, exp_idx, pops = 0, job_pop_base = 0;
    int            done_cnt = 0, done_cyc = -1;

    // Compare process: checks every cycle against the element-index model
    always @(negedge clk) begin
        logic [DW-1:0] w;
        logic [EW-1:0] exp_d;
        if (chk_reset) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_valid", elem_valid, 0);
            chk("rst_last", elem_last, 0);
            chk("rst_rd_en", fifo_rd_en, 0);
            chk("rst_rd_cs", fifo_rd_cs, 0);
            chk_reset = 1'b0;
        end
        if (!rst) begin
            model_words.delete();
            job_active = 1'b0;
            exp_done   = 1'b0;
            stall_prev = 1'b0;
            chk_reset  = 1'b1;
        end else begin
            if (push_valid) model_words.push_back(push_word);
            chk("done", done, exp_done);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            exp_done = 1'b0;
            chk("rd_cs_eq_rd_en", fifo_rd_cs, fifo_rd_en);
            chk("pop_while_empty", fifo_rd_en && fifo_empty, 0);
            chk("valid_implies_busy", elem_valid && !busy, 0);
            if (fifo_rd_en) begin
                pops++;
                pop_cyc.push_back(cyc);
            end
            if (stall_prev) begin
                chk("stall_valid_held", elem_valid, 1);
                chk("stall_data_held", elem_data, prev_data);
                chk("stall_last_held", elem_last, prev_last);
            end
            if (elem_valid) begin
                if (!job_active) begin
                    chk("valid_without_job", elem_valid, 0);
                end else if (exp_idx / EPW >= model_words.size()) begin
                    chk("model_underrun", 1, 0);
                end else begin
                    w     = model_words[exp_idx / EPW];
                    exp_d = EW'(w >> (EW * (exp_idx % EPW)));
                    chk("elem_data", elem_data, exp_d);
                    chk("elem_last", elem_last, (exp_idx == job_len - 1));
                    if (!elem_ready) chk("pop_in_stall", fifo_rd_en, 0);
                    if (elem_ready) begin
                        acc_log.push_back(elem_data);
                        acc_cyc.push_back(cyc);
                        exp_idx++;
                        if (exp_idx == job_len) begin
                            exp_done   = 1'b1;
                            job_active = 1'b0;
                            chk("job_pops", pops - job_pop_base, (job_len + EPW - 1) / EPW);
                            for (int i = 0; i < (job_len + EPW - 1) / EPW; i++)
                                if (model_words.size() != 0) void'(model_words.pop_front());
                        end
                    end
                end
            end
            stall_prev = elem_valid && !elem_ready;
            prev_data  = elem_data;
            prev_last  = elem_last;
            if (start && !busy) begin
                job_len      = int'(vec_len);
                exp_idx      = 0;
                job_pop_base = pops;
                job_active   = (vec_len != '0);
                if (vec_len == '0) exp_done = 1'b1;
            end
        end
    end

    // Driver side
    logic [EW-1:0] exp1[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    bit            pat[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    int            start_cyc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        push_valid = 1'b1;
        push_word  = w;
        step();
        push_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input bit toggle, input bit busy_start);
        int k = 0;
        while (done_cnt == d0 && k < 200) begin
            elem_ready = toggle ? pat[k % 4] : 1'b1;
            if (busy_start && (k == 2 || k == 4)) begin
                start   = 1'b1;
                vec_len = LW'(3);
            end else begin
                start = 1'b0;
            end
            step();
            k++;
        end
        start      = 1'b0;
        elem_ready = 1'b1;
        if (done_cnt == d0) chk("done_timeout", 0, 1);
    endtask

    task automatic run_job(input int len, input bit toggle, input bit busy_start);
        int d0 = done_cnt;
        start     = 1'b1;
        vec_len   = LW'(len);
        start_cyc = cyc;
        step();
        start = 1'b0;
        wait_done(d0, toggle, busy_start);
    endtask

    task automatic chk_seq(input string name, input int lb, input int n, input logic [EW-1:0] first, input logic [EW-1:0] incr);
        chk({name, "_count"}, acc_log.size() - lb, n);
        if (acc_log.size() - lb == n)
            for (int i = 0; i < n; i++) chk(name, acc_log[lb + i], EW'(first + EW'(i) * incr));
    endtask

    initial begin
        int lb, pb, d0;
        rst = 1'b0; start = 1'b0; vec_len = '0; elem_ready = 1'b1;
        push_valid = 1'b0; push_word = '0;
        repeat (3) step();
        rst = 1'b1;
        step();

        // Two full words streamed back to back
        push(32'h44332211); push(32'h88776655); step();
        lb = acc_log.size(); pb = pop_cyc.size();
        run_job(8, 1'b0, 1'b0);
        chk("s1_count", acc_log.size() - lb, 8);
        if (acc_log.size() - lb == 8)
            for (int i = 0; i < 8; i++) chk("s1_elem", acc_log[lb + i], exp1[i]);
        chk("s1_pops", pop_cyc.size() - pb, 2);
        if (pop_cyc.size() - pb == 2 && acc_log.size() - lb == 8) begin
            chk("s1_pop2_with_44", pop_cyc[pb + 1], acc_cyc[lb + 3]);
            chk("s1_done_after_88", done_cyc, acc_cyc[lb + 7] + 1);
            chk("s1_first_after_pop", acc_cyc[lb], pop_cyc[pb] + 1);
        end

        // Partial word discard, then a one-element job
        push(32'h44332211); push(32'h88776655); push(32'hCCBBAA99); step();
        lb = acc_log.size(); pb = pop_cyc.size();
        run_job(5, 1'b0, 1'b0);
        chk_seq("s2_elem", lb, 5, 8'h11, 8'h11);
        chk("s2_pops", pop_cyc.size() - pb, 2);
        lb = acc_log.size();
        run_job(1, 1'b0, 1'b0);
        chk_seq("s2b_elem", lb, 1, 8'h99, 8'h00);

        // Empty FIFO at start: wait in FETCH until a word arrives
        lb = acc_log.size(); pb = pop_cyc.size(); d0 = done_cnt;
        start = 1'b1; vec_len = LW'(4); step(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("s3_no_valid", elem_valid, 0);
            chk("s3_no_pop", fifo_rd_en, 0);
            step();
        end
        push(32'hDDCCBBAA);
        wait_done(d0, 1'b0, 1'b0);
        chk_seq("s3_elem", lb, 4, 8'hAA, 8'h11);
        chk("s3_pops", pop_cyc.size() - pb, 1);
        if (pop_cyc.size() - pb == 1 && acc_log.size() - lb == 4)
            chk("s3_valid_after_pop", acc_cyc[lb], pop_cyc[pb] + 1);

        // Backpressure with ready pattern 1,0,0,1
        push(32'h44332211); push(32'h88776655); step();
        lb = acc_log.size(); pb = pop_cyc.size();
        run_job(8, 1'b1, 1'b0);
        chk("s4_count", acc_log.size() - lb, 8);
        if (acc_log.size() - lb == 8)
            for (int i = 0; i < 8; i++) chk("s4_elem", acc_log[lb + i], exp1[i]);
        if (pop_cyc.size() - pb == 2 && acc_log.size() - lb == 8)
            chk("s4_pop2_with_44", pop_cyc[pb + 1], acc_cyc[lb + 3]);
        else
            chk("s4_pops", pop_cyc.size() - pb, 2);

        // Zero-length job
        lb = acc_log.size(); pb = pop_cyc.size();
        run_job(0, 1'b0, 1'b0);
        chk("s5_done_cyc", done_cyc, start_cyc + 1);
        chk("s5_pops", pop_cyc.size() - pb, 0);
        chk("s5_elems", acc_log.size() - lb, 0);

        // Reset after three accepts, then a clean job with ignored busy starts
        push(32'h44332211); push(32'h88776655); step();
        lb = acc_log.size(); d0 = done_cnt;
        start = 1'b1; vec_len = LW'(8); step(); start = 1'b0;
        for (int i = 0; i < 50 && acc_log.size() - lb < 3; i++) step();
        chk("s6_three_accepts", acc_log.size() - lb, 3);
        rst = 1'b0; step(); rst = 1'b1;
        repeat (4) step();
        chk("s6_no_done", done_cnt, d0);
        chk("s6_idle", busy, 0);
        push(32'h04030201); step();
        lb = acc_log.size();
        run_job(4, 1'b0, 1'b1);
        chk_seq("s6_elem", lb, 4, 8'h01, 8'h01);
        repeat (3) step();
        chk("s6_final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
